adc_snap_capture: RTL and testbench

- Snapshot capture controller, directly downstream of the snapshot ctrl software register. Consumes its 32-bit control word (user_data_out) in the user_clk domain.
- Arms, waits for a trigger, then writes a block of ADC samples into a snapshot BRAM.
- Exports a 32-bit status word for a readback register.

---
 rtl/adc_snap_capture_pkg.sv | 25 ++
 rtl/adc_snap_capture_if.sv | 41 ++++
 rtl/adc_snap_capture_rise_det.sv | 24 ++
 rtl/adc_snap_capture.sv | 147 ++++++++++++++
 tb/tb_adc_snap_capture.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_snap_capture_pkg.sv
// snap_pkg: shared types and bit-position constants for the ADC snapshot
// capture controller (adc_snap_capture).
//   state_t      capture FSM states
//   CTRL_*       bit positions inside the 32-bit control word
//   ST_*         bit/field positions inside the 32-bit status word
package snap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_TSRC  = 1;
  localparam int CTRL_WEALL = 2;
  localparam int CTRL_STOP  = 3;

  localparam int ST_DONE    = 0;
  localparam int ST_ARMED   = 1;
  localparam int ST_CAP     = 2;
  localparam int ST_CNT_LSB = 16;

endpackage

// File: rtl/adc_snap_capture_if.sv
// adc_snap_capture_if: control/data/BRAM-write bundle of the snapshot
// capture controller.
//   ctrl[31:0]        control word (arm, trig_src, we_all, stop)
//   din, din_valid    ADC word and its qualifier
//   trig              external trigger, level-sampled
//   trig_offset[31:0] qualified samples to skip after the trigger
//                     (present only when SNAP_TRIG_OFFSET_EN is defined)
//   bram_addr/data/we registered BRAM write port
//   status[31:0]      readback status word
// Modports: master = source of control/data (software/ADC side),
//           slave  = the capture controller.
interface adc_snap_capture_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 11
);

  logic [31:0]       ctrl;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              trig;
`ifdef SNAP_TRIG_OFFSET_EN
  logic [31:0]       trig_offset;
`endif
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic [31:0]       status;

`ifdef SNAP_TRIG_OFFSET_EN
  modport master (output ctrl, din, din_valid, trig, trig_offset,
                  input  bram_addr, bram_data, bram_we, status);
  modport slave  (input  ctrl, din, din_valid, trig, trig_offset,
                  output bram_addr, bram_data, bram_we, status);
`else
  modport master (output ctrl, din, din_valid, trig,
                  input  bram_addr, bram_data, bram_we, status);
  modport slave  (input  ctrl, din, din_valid, trig,
                  output bram_addr, bram_data, bram_we, status);
`endif

endinterface

// File: rtl/adc_snap_capture_rise_det.sv
// snap_rise_det: single-bit registered rising-edge detector.
//   clk   clock
//   rst   asynchronous active-high reset (history flop cleared to 0)
//   d     input level
//   rise  d & ~d_previous, combinational from d
module snap_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/adc_snap_capture.sv
// adc_snap_capture: arms on a rising edge of ctrl[0], waits for a trigger
// (immediate or external), then writes qualified ADC words into a snapshot
// BRAM at addresses 0..DEPTH-1 and reports progress in a status word.
//   user_clk   sole clock, rising edge
//   user_rst   asynchronous active-high reset
//   bus        adc_snap_capture_if.slave (ctrl, din, din_valid, trig,
//              bram_addr, bram_data, bram_we, status[, trig_offset])
// Optional build macro SNAP_TRIG_OFFSET_EN: after the trigger, the first
// trig_offset qualified samples are discarded before writing starts.
module adc_snap_capture
  import snap_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 11
) (
  input logic               user_clk,
  input logic               user_rst,
  adc_snap_capture_if.slave bus
);

  localparam int LAST_IDX = (1 << ADDR_W) - 1;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr;
  logic              arm_rise, qual, hit, stop, last;
  logic              bram_we_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_data_q;
  logic [31:0]       status_q, status_d;
  logic              unused_ctrl;
`ifdef SNAP_TRIG_OFFSET_EN
  logic [31:0]       skip_q, skip_d;
`endif

  snap_rise_det u_arm_det (
    .clk  (user_clk),
    .rst  (user_rst),
    .d    (bus.ctrl[CTRL_ARM]),
    .rise (arm_rise)
  );

  assign qual        = bus.ctrl[CTRL_WEALL] | bus.din_valid;
  assign hit         = bus.ctrl[CTRL_TSRC] ? bus.trig : 1'b1;
  assign stop        = bus.ctrl[CTRL_STOP];
  assign last        = (cnt_q == LAST_IDX[ADDR_W:0]);
  assign unused_ctrl = ^bus.ctrl[31:4];

  // Per-cycle priority: arm_rise > last-address write > stop > normal write.
  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr      = 1'b0;
`ifdef SNAP_TRIG_OFFSET_EN
    skip_d  = skip_q;
`endif
    if (arm_rise) begin
      // Arm edge restarts from any state; no write in this cycle.
      state_d = ARMED;
      cnt_d   = '0;
`ifdef SNAP_TRIG_OFFSET_EN
      skip_d  = '0;
`endif
    end else begin
      case (state_q)
        ARMED: begin
          if (stop) begin
            state_d = DONE;
            cnt_d   = '0;
          end else if (hit) begin
            state_d = CAPTURE;
`ifdef SNAP_TRIG_OFFSET_EN
            // The hit-cycle sample is the first candidate for discarding.
            if (bus.trig_offset != 32'd0) skip_d = bus.trig_offset - {31'd0, qual};
            else                          wr     = qual;
`else
            wr = qual;
`endif
          end
        end
        CAPTURE: begin
`ifdef SNAP_TRIG_OFFSET_EN
          if (skip_q != 32'd0) begin
            // Nothing written yet, so stopping here leaves count at 0.
            if (stop)      state_d = DONE;
            else if (qual) skip_d  = skip_q - 32'd1;
          end else
`endif
          if (qual && last) begin
            wr      = 1'b1;
            state_d = DONE;
          end else if (stop) begin
            state_d = DONE;
          end else begin
            wr = qual;
          end
        end
        default: ;  // IDLE and DONE hold until an arm edge
      endcase
      // Count can only reach DEPTH: the write at DEPTH-1 moves to DONE.
      if (wr) cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    status_d                             = '0;
    status_d[ST_DONE]                    = (state_q == DONE);
    status_d[ST_ARMED]                   = (state_q == ARMED);
    status_d[ST_CAP]                     = (state_q == CAPTURE);
    status_d[ST_CNT_LSB +: ADDR_W + 1]   = cnt_q;
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
      status_q    <= '0;
`ifdef SNAP_TRIG_OFFSET_EN
      skip_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bram_we_q <= wr;
      status_q  <= status_d;
`ifdef SNAP_TRIG_OFFSET_EN
      skip_q    <= skip_d;
`endif
      // Address and data only move on a write; they hold otherwise.
      if (wr) begin
        bram_addr_q <= cnt_q[ADDR_W-1:0];
        bram_data_q <= bus.din;
      end
    end
  end

  assign bus.bram_we   = bram_we_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_data = bram_data_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_adc_snap_capture.sv
// tb_adc_snap_capture: self-checking bench for adc_snap_capture (ADDR_W=4).
// A behavioural model runs alongside the DUT and is compared every cycle;
// each scenario task also checks its own expected write list and status.
// Define SNAP_TRIG_OFFSET_EN for the trigger-offset build.
module tb_adc_snap_capture;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_CAP   = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    int                mode;
    int                cnt;
    int                skip;
    bit                prev;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [31:0]       status;
  } mdl_t;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic user_clk;
  logic user_rst;

  adc_snap_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  adc_snap_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .bus      (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   mdl_wr_n = 0;
  bit   din_inc  = 0;
  wr_t  wr_q[$];
  mdl_t m;

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // ---------------- behavioural reference model ----------------
  function automatic int unsigned cur_off();
`ifdef SNAP_TRIG_OFFSET_EN
    return bus.trig_offset;
`else
    return 0;
`endif
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = M_IDLE; r.cnt = 0; r.skip = 0; r.prev = 1'b0; r.we = 1'b0;
    r.addr = '0; r.data = '0; r.status = '0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t cur, logic [31:0] c, logic [DATA_W-1:0] d,
                                    logic v, logic t, int unsigned off);
    mdl_t n;
    bit rise, qual, hit, stop, wr;
    n    = cur;
    rise = c[0] && !cur.prev;
    qual = c[2] || v;
    hit  = c[1] ? t : 1'b1;
    stop = c[3];
    wr   = 1'b0;
    n.prev   = c[0];
    n.we     = 1'b0;
    n.status = {16'(cur.cnt), 13'd0, (cur.mode == M_CAP), (cur.mode == M_ARMED),
                (cur.mode == M_DONE)};
    if (rise) begin
      n.mode = M_ARMED; n.cnt = 0; n.skip = 0;
    end else if (cur.mode == M_ARMED) begin
      if (stop) begin
        n.mode = M_DONE; n.cnt = 0;
      end else if (hit) begin
        n.mode = M_CAP;
        n.skip = int'(off);
        if (qual) begin
          if (n.skip > 0) n.skip = n.skip - 1;
          else            wr = 1'b1;
        end
      end
    end else if (cur.mode == M_CAP) begin
      if (cur.skip > 0) begin
        if (stop)      n.mode = M_DONE;
        else if (qual) n.skip = cur.skip - 1;
      end else if (qual && cur.cnt == DEPTH - 1) begin
        wr = 1'b1; n.mode = M_DONE;
      end else if (stop) begin
        n.mode = M_DONE;
      end else if (qual) begin
        wr = 1'b1;
      end
    end
    if (wr) begin
      n.we   = 1'b1;
      n.addr = ADDR_W'(cur.cnt);
      n.data = d;
      n.cnt  = cur.cnt + 1;
    end
    return n;
  endfunction

  always @(posedge user_clk or posedge user_rst) begin
    if (user_rst) m <= mdl_reset();
    else          m <= mdl_step(m, bus.ctrl, bus.din, bus.din_valid, bus.trig, cur_off());
  end

  always @(posedge user_clk) cyc <= cyc + 1;

  // Sample outputs on the falling edge: log writes and compare to the model.
  always @(negedge user_clk) begin
    if (!user_rst) begin
      if (bus.bram_we === 1'b1) wr_q.push_back('{cyc: cyc, addr: bus.bram_addr, data: bus.bram_data});
      if (m.we) mdl_wr_n++;
      n_checks++;
      if (bus.bram_we !== m.we || bus.bram_addr !== m.addr || bus.status !== m.status ||
          (m.we && bus.bram_data !== m.data))
        $display("FAIL model_cycle %0d: we/addr/data/status got %0b/%0h/%0h/%0h want %0b/%0h/%0h/%0h",
                 cyc, bus.bram_we, bus.bram_addr, bus.bram_data, bus.status,
                 m.we, m.addr, m.data, m.status);
      else n_pass++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge user_clk);
      #1;
      if (din_inc) bus.din = bus.din + 1'b1;
      else         bus.din = {$urandom, $urandom};
    end
  endtask

  task automatic do_reset();
    user_rst      = 1'b1;
    bus.ctrl      = '0;
    bus.din_valid = 1'b0;
    bus.trig      = 1'b0;
    din_inc       = 1'b0;
`ifdef SNAP_TRIG_OFFSET_EN
    bus.trig_offset = '0;
`endif
    tick(2);
    user_rst = 1'b0;
    wr_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    user_rst = 1'b1;
    tick(2);
    n_checks++;
    if (bus.bram_we !== 1'b0 || bus.bram_addr !== '0 || bus.bram_data !== '0 || bus.status !== 32'd0)
      $display("FAIL reset_outputs: we/addr/data/status got %0b/%0h/%0h/%0h want 0/0/0/0",
               bus.bram_we, bus.bram_addr, bus.bram_data, bus.status);
    else n_pass++;
    do_reset();
    bus.din_valid = 1'b1;
    tick(4);
    n_checks++;
    if (bus.status !== 32'd0 || wr_q.size() != 0)
      $display("FAIL reset_idle: status got %0h writes %0d want 0 and 0", bus.status, wr_q.size());
    else n_pass++;
  endtask

  task automatic test_immediate();
    int arm_cyc;
    do_reset();
    bus.din_valid = 1'b1;
    din_inc       = 1'b1;
    bus.din       = DATA_W'(32'h0F);
    bus.ctrl      = 32'h1;
    arm_cyc       = cyc + 1;
    tick(20);
    n_checks++;
    if (wr_q.size() != 16) $display("FAIL imm_count got %0d want 16", wr_q.size());
    else n_pass++;
    for (int i = 0; i < wr_q.size() && i < 16; i++) begin
      n_checks++;
      if (wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== DATA_W'(16 + i))
        $display("FAIL imm_write[%0d] addr/data got %0h/%0h want %0h/%0h",
                 i, wr_q[i].addr, wr_q[i].data, i, 16 + i);
      else n_pass++;
    end
    if (wr_q.size() > 0) begin
      n_checks++;
      if (wr_q[0].cyc != arm_cyc + 1)
        $display("FAIL imm_latency first write cycle got %0d want %0d", wr_q[0].cyc, arm_cyc + 1);
      else n_pass++;
    end
    n_checks++;
    if (bus.status !== 32'h0010_0001 || bus.bram_we !== 1'b0)
      $display("FAIL imm_status got %0h we %0b want 00100001 we 0", bus.status, bus.bram_we);
    else n_pass++;
  endtask

  task automatic test_ext_trig();
    logic [DATA_W-1:0] trig_din;
    do_reset();
    bus.din_valid = 1'b1;
    bus.ctrl      = 32'h3;
    tick(20);
    n_checks++;
    if (bus.status !== 32'h0000_0002 || wr_q.size() != 0)
      $display("FAIL trig_wait status got %0h writes %0d want 00000002 and 0", bus.status, wr_q.size());
    else n_pass++;
    bus.trig = 1'b1;
    trig_din = bus.din;
    tick(1);
    bus.trig = 1'b0;
    tick(20);
    n_checks++;
    if (wr_q.size() != 16) $display("FAIL trig_count got %0d want 16", wr_q.size());
    else n_pass++;
    if (wr_q.size() > 0) begin
      n_checks++;
      if (wr_q[0].addr !== '0 || wr_q[0].data !== trig_din)
        $display("FAIL trig_first addr/data got %0h/%0h want 0/%0h", wr_q[0].addr, wr_q[0].data, trig_din);
      else n_pass++;
    end
    n_checks++;
    if (bus.status !== 32'h0010_0001) $display("FAIL trig_status got %0h want 00100001", bus.status);
    else n_pass++;
  endtask

  task automatic test_valid_gaps();
    logic [DATA_W-1:0] vq[$];
    do_reset();
    bus.ctrl = 32'h1;
    tick(1);
    for (int i = 0; i < 16; i++) begin
      bus.din_valid = (i % 2 == 0);
      if (bus.din_valid) vq.push_back(bus.din);
      tick(1);
    end
    bus.din_valid = 1'b0;
    tick(4);
    n_checks++;
    if (wr_q.size() != 8) $display("FAIL gaps_count got %0d want 8", wr_q.size());
    else n_pass++;
    for (int i = 0; i < wr_q.size() && i < 8; i++) begin
      n_checks++;
      if (wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== vq[i])
        $display("FAIL gaps_write[%0d] addr/data got %0h/%0h want %0h/%0h",
                 i, wr_q[i].addr, wr_q[i].data, i, vq[i]);
      else n_pass++;
    end
    n_checks++;
    if (bus.status !== 32'h0008_0004) $display("FAIL gaps_status got %0h want 00080004", bus.status);
    else n_pass++;
  endtask

  task automatic test_stop_rearm();
    int guard = 0;
    do_reset();
    bus.din_valid = 1'b1;
    bus.ctrl      = 32'h1;
    while (wr_q.size() < 5 && guard < 40) begin
      tick(1);
      guard++;
    end
    n_checks++;
    if (wr_q.size() != 5) $display("FAIL stop_reach5 writes got %0d want 5 within 40 cycles", wr_q.size());
    else n_pass++;
    bus.ctrl = 32'h9;
    tick(1);
    n_checks++;
    if (bus.bram_we !== 1'b0) $display("FAIL stop_we got %0b want 0", bus.bram_we);
    else n_pass++;
    tick(3);
    n_checks++;
    if (bus.status !== 32'h0005_0001 || wr_q.size() != 5)
      $display("FAIL stop_status got %0h writes %0d want 00050001 and 5", bus.status, wr_q.size());
    else n_pass++;
    bus.ctrl = 32'h0;
    tick(1);
    wr_q.delete();
    bus.ctrl = 32'h1;
    tick(2);
    n_checks++;
    if (bus.status !== 32'h0000_0002) $display("FAIL rearm_status got %0h want 00000002", bus.status);
    else n_pass++;
    tick(20);
    n_checks++;
    if (wr_q.size() != 16 || wr_q[0].addr !== '0)
      $display("FAIL rearm_writes count got %0d want 16, first addr must be 0", wr_q.size());
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.din_valid = 1'b1;
    bus.ctrl      = 32'h1;
    tick(6);
    n_checks++;
    if (bus.bram_we !== 1'b1) $display("FAIL areset_precond we got %0b want 1", bus.bram_we);
    else n_pass++;
    #2;
    user_rst = 1'b1;
    #1;
    n_checks++;
    if (bus.bram_we !== 1'b0 || bus.status !== 32'd0)
      $display("FAIL areset_immediate we/status got %0b/%0h want 0/0", bus.bram_we, bus.status);
    else n_pass++;
    bus.ctrl = 32'h9;
    tick(2);
    user_rst = 1'b0;
    wr_q.delete();
    tick(6);
    n_checks++;
    if (bus.status !== 32'h0000_0001 || wr_q.size() != 0)
      $display("FAIL areset_release status got %0h writes %0d want 00000001 and 0", bus.status, wr_q.size());
    else n_pass++;
    bus.ctrl = 32'h1;
    tick(10);
    n_checks++;
    if (wr_q.size() != 0) $display("FAIL areset_held_arm writes got %0d want 0", wr_q.size());
    else n_pass++;
    bus.ctrl = 32'h0;
    tick(1);
    bus.ctrl = 32'h1;
    tick(20);
    n_checks++;
    if (wr_q.size() != 16 || bus.status !== 32'h0010_0001)
      $display("FAIL areset_toggle writes %0d status %0h want 16 and 00100001", wr_q.size(), bus.status);
    else n_pass++;
  endtask

`ifdef SNAP_TRIG_OFFSET_EN
  task automatic test_offset();
    do_reset();
    bus.trig_offset = 32'd3;
    bus.din_valid   = 1'b1;
    din_inc         = 1'b1;
    bus.din         = '1;
    bus.ctrl        = 32'h1;
    tick(24);
    n_checks++;
    if (wr_q.size() != 16) $display("FAIL offset_count got %0d want 16", wr_q.size());
    else n_pass++;
    if (wr_q.size() > 0) begin
      n_checks++;
      if (wr_q[0].addr !== '0 || wr_q[0].data !== DATA_W'(3))
        $display("FAIL offset_first addr/data got %0h/%0h want 0/3", wr_q[0].addr, wr_q[0].data);
      else n_pass++;
    end
    do_reset();
    bus.trig_offset = 32'd10;
    bus.din_valid   = 1'b1;
    bus.ctrl        = 32'h1;
    tick(4);
    n_checks++;
    if (bus.status !== 32'h0000_0004) $display("FAIL offset_skip_status got %0h want 00000004", bus.status);
    else n_pass++;
    bus.ctrl = 32'h9;
    tick(3);
    n_checks++;
    if (bus.status !== 32'h0000_0001 || wr_q.size() != 0)
      $display("FAIL offset_stop status got %0h writes %0d want 00000001 and 0", bus.status, wr_q.size());
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    bit arm   = 1'b0;
    bit tsrc  = 1'b0;
    bit weall = 1'b0;
    bit stop  = 1'b0;
    do_reset();
    mdl_wr_n = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        arm = !arm;
        if (arm) begin
          tsrc  = 1'($urandom_range(0, 1));
          weall = ($urandom_range(0, 3) == 0);
`ifdef SNAP_TRIG_OFFSET_EN
          bus.trig_offset = $urandom_range(0, 4);
`endif
        end
      end
      if (!stop && $urandom_range(0, 59) == 0)     stop = 1'b1;
      else if (stop && $urandom_range(0, 4) == 0)  stop = 1'b0;
      bus.ctrl      = {28'd0, stop, weall, tsrc, arm};
      bus.din_valid = ($urandom_range(0, 3) != 0);
      bus.trig      = ($urandom_range(0, 9) == 0);
      tick(1);
    end
    bus.ctrl = 32'h0;
    tick(2);
    n_checks++;
    if (wr_q.size() != mdl_wr_n)
      $display("FAIL random_write_total got %0d want %0d", wr_q.size(), mdl_wr_n);
    else n_pass++;
  endtask

  initial begin
    user_rst      = 1'b1;
    bus.ctrl      = '0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.trig      = 1'b0;
`ifdef SNAP_TRIG_OFFSET_EN
    bus.trig_offset = '0;
`endif
    test_reset();
    test_immediate();
    test_ext_trig();
    test_valid_gaps();
    test_stop_rearm();
    test_async_reset();
`ifdef SNAP_TRIG_OFFSET_EN
    test_offset();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
